// File: rtl/mult_div_ctrl_if.sv
// Handshake and result bus between the main control FSM and the
// multiply/divide sequencer.
interface mult_div_ctrl_if;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        mult_we;
  logic        div_we;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  // Main control FSM side: issues requests, consumes results.
  modport master (
    output start_mult, start_div, op_a, op_b,
    input  busy, done, mult_we, div_we, div_zero, hi, lo
  );

  // Sequencer side: accepts requests, produces results.
  modport slave (
    input  start_mult, start_div, op_a, op_b,
    output busy, done, mult_we, div_we, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// Multiply/divide sequencer for the multicycle MIPS datapath.
// Runs a 32-step radix-2 Booth signed multiply or a 32-step restoring
// signed divide, then pulses the matching HI/LO load enable.
module mult_div_ctrl (
  input  logic            clk,
  input  logic            reset,
  mult_div_ctrl_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DZERO = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state;
  logic [31:0] acc;      // Booth A, or divide partial remainder R
  logic [31:0] q;        // Booth Q (multiplier), or dividend/quotient
  logic        q_m1;     // Booth q-1 bit
  logic [31:0] m;        // multiplicand, or divisor magnitude
  logic [5:0]  cnt;
  logic        neg_a;    // dividend was negative
  logic        neg_b;    // divisor was negative
  logic        is_mult;  // current operation is a multiply

  logic [32:0] booth_sum;
  logic [31:0] booth_a_next;
  logic [31:0] booth_q_next;
  logic [32:0] r_shift;
  logic [33:0] r_diff;
  logic [31:0] div_r_next;
  logic [31:0] div_q_next;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  // One Booth step and one restoring-divide step, computed from current state.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    booth_sum = {acc[31], acc};
    case ({q[0], q_m1})
      2'b01:   booth_sum = {acc[31], acc} + {m[31], m};
      2'b10:   booth_sum = {acc[31], acc} - {m[31], m};
      default: booth_sum = {acc[31], acc};
    endcase
    // The 33-bit sum keeps -(-2^31) exact; the arithmetic shift drops bit 0 into Q.
    booth_a_next = booth_sum[32:1];
    booth_q_next = {booth_sum[0], q[31:1]};

    r_shift = {acc, q[31]};
    r_diff  = {1'b0, r_shift} - {2'b00, m};
    if (r_diff[33]) begin
      div_r_next = r_shift[31:0];
    end else begin
      div_r_next = r_diff[31:0];
    end
    div_q_next = {q[30:0], ~r_diff[33]};

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quot_fix = (neg_a ^ neg_b) ? (32'd0 - div_q_next) : div_q_next;
    rem_fix  = neg_a ? (32'd0 - div_r_next) : div_r_next;

    abs_a = bus.op_a[31] ? (32'd0 - bus.op_a) : bus.op_a;
    abs_b = bus.op_b[31] ? (32'd0 - bus.op_b) : bus.op_b;
  end

  // Control FSM and datapath registers; reset wins over any start.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      m       <= '0;
      cnt     <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      is_mult <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_mult) begin
            state   <= MULT;
            acc     <= '0;
            q       <= bus.op_b;
            q_m1    <= 1'b0;
            m       <= bus.op_a;
            cnt     <= '0;
            is_mult <= 1'b1;
          end else if (bus.start_div) begin
            is_mult <= 1'b0;
            if (bus.op_b == 32'd0) begin
              // hi/lo are left untouched on a divide-by-zero.
              state <= DZERO;
            end else begin
              state <= DIV;
              acc   <= '0;
              q     <= abs_a;
              m     <= abs_b;
              neg_a <= bus.op_a[31];
              neg_b <= bus.op_b[31];
              cnt   <= '0;
            end
          end
        end
        MULT: begin
          acc  <= booth_a_next;
          q    <= booth_q_next;
          q_m1 <= q[0];
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) state <= DONE;
        end
        DIV: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            acc   <= rem_fix;
            q     <= quot_fix;
            state <= DONE;
          end else begin
            acc <= div_r_next;
            q   <= div_q_next;
          end
        end
        DONE:    state <= IDLE;
        DZERO:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Status and load enables decode directly from the state.
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.done     = (state == DONE) || (state == DZERO);
    bus.mult_we  = (state == DONE) && is_mult;
    bus.div_we   = (state == DONE) && !is_mult;
    bus.div_zero = (state == DZERO);
    bus.hi       = acc;
    bus.lo       = q;
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed self-checking bench for mult_div_ctrl.
module tb_mult_div_ctrl;

  logic clk;
  logic reset;
  mult_div_ctrl_if bus ();

  mult_div_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-operation observations, filled by run_op.
  int          n_done, n_mwe, n_dwe, n_dz, n_busy;
  int          done_cyc, mwe_cyc, dwe_cyc, dz_cyc;
  logic [31:0] done_hi, done_lo;
  logic [69:0] rst_snap;
  logic        end_busy;
  logic [31:0] end_hi, end_lo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue a start just before edge 0, then watch cycles 1..40 at the falling edge.
  // inject_k: assert start_div during that cycle; reset_k: assert reset during that cycle.
  task automatic run_op(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b,
                        input int inject_k, input int reset_k);
    n_done = 0; n_mwe = 0; n_dwe = 0; n_dz = 0; n_busy = 0;
    done_cyc = 0; mwe_cyc = 0; dwe_cyc = 0; dz_cyc = 0;
    done_hi = 'x; done_lo = 'x; rst_snap = 'x;
    @(negedge clk);
    bus.start_mult = sm;
    bus.start_div  = sd;
    bus.op_a       = a;
    bus.op_b       = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy) n_busy++;
      if (bus.done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = k; done_hi = bus.hi; done_lo = bus.lo;
        end
      end
      if (bus.mult_we)  begin n_mwe++; if (mwe_cyc == 0) mwe_cyc = k; end
      if (bus.div_we)   begin n_dwe++; if (dwe_cyc == 0) dwe_cyc = k; end
      if (bus.div_zero) begin n_dz++;  if (dz_cyc == 0)  dz_cyc = k;  end
      if (k == reset_k + 1)
        rst_snap = {bus.busy, bus.done, bus.mult_we, bus.div_we, bus.div_zero,
                    bus.hi, bus.lo, 1'b0};
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      if (k == inject_k) begin
        bus.start_div = 1'b1;
        bus.op_a      = 32'd9;
        bus.op_b      = 32'd0;
      end
      reset = (k == reset_k);
    end
    end_busy = bus.busy;
    end_hi   = bus.hi;
    end_lo   = bus.lo;
  endtask

  // Standard result checks for a completed multiply or divide.
  task automatic check_op(input string tag, input bit is_mult, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'd33);
    check({tag, "_n_done"}, 64'(n_done), 64'd1);
    check({tag, "_n_busy"}, 64'(n_busy), 64'd33);
    check({tag, "_we_cyc"}, 64'(is_mult ? mwe_cyc : dwe_cyc), 64'd33);
    check({tag, "_n_mwe"}, 64'(n_mwe), is_mult ? 64'd1 : 64'd0);
    check({tag, "_n_dwe"}, 64'(n_dwe), is_mult ? 64'd0 : 64'd1);
    check({tag, "_n_dz"}, 64'(n_dz), 64'd0);
    check({tag, "_hi"}, 64'(done_hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(done_lo), 64'(exp_lo));
    check({tag, "_idle"}, 64'(end_busy), 64'd0);
    check({tag, "_hold"}, {end_hi, end_lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    reset          = 1'b1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    repeat (2) @(negedge clk);
    check("rst_status", {59'd0, bus.busy, bus.done, bus.mult_we, bus.div_we, bus.div_zero}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;

    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 0, 0);
    check_op("mul_7_m3", 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, 0);
    check_op("mul_min_min", 1, 32'h4000_0000, 32'h0000_0000);

    run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check_op("mul_m1_m1", 1, 32'h0, 32'h1);

    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check_op("div_m7_2", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check_op("div_ovf", 0, 32'h0, 32'h8000_0000);

    run_op(0, 1, 32'd100, 32'd7, 0, 0);
    check_op("div_100_7", 0, 32'd2, 32'd14);

    run_op(0, 1, 32'd5, 32'd0, 0, 0);
    check("dz_done_cyc", 64'(done_cyc), 64'd1);
    check("dz_cyc", 64'(dz_cyc), 64'd1);
    check("dz_n_done", 64'(n_done), 64'd1);
    check("dz_n_busy", 64'(n_busy), 64'd1);
    check("dz_n_we", 64'(n_mwe + n_dwe), 64'd0);
    check("dz_hilo", {done_hi, done_lo}, {32'd2, 32'd14});
    check("dz_hold", {end_hi, end_lo}, {32'd2, 32'd14});

    run_op(1, 1, 32'd6, 32'd7, 0, 0);
    check_op("both_start", 1, 32'd0, 32'd42);

    run_op(1, 0, 32'd5, 32'hFFFF_FFFA, 10, 0);
    check_op("late_div", 1, 32'hFFFF_FFFF, 32'hFFFF_FFE2);

    run_op(0, 1, 32'd100, 32'd7, 0, 10);
    check("abort_outputs", rst_snap[63:0] | {58'd0, rst_snap[69:64]}, 64'd0);
    check("abort_n_done", 64'(n_done), 64'd0);
    check("abort_n_we", 64'(n_mwe + n_dwe), 64'd0);

    run_op(1, 0, 32'd3, 32'd4, 0, 0);
    check_op("mul_3_4", 1, 32'd0, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
